// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchronized RX line, oversampled start/data/parity/stop decoding,
// byte hand-off with ready/overrun tracking. Optional macro RX_MAJORITY_VOTE_EN selects 2-of-3 bit voting.
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 RX_in,
  input  logic                 RX_read,
  output logic [DATA_BITS-1:0] RX_data_out,
  output logic                 RX_valid,
  output logic                 RX_ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 RXbusy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [SW-1:0] LAST_TICK = SW'(OVERSAMPLE - 1);
`ifdef RX_MAJORITY_VOTE_EN
  localparam logic [SW-1:0] START_TICK = SW'(OVERSAMPLE / 2);
`else
  localparam logic [SW-1:0] START_TICK = SW'(OVERSAMPLE / 2 - 1);
`endif
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic                 bit_smp;
  logic [2:0]           state_q, state_d;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ready_q, ready_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  assign rx_s = sync_q[1];

`ifdef RX_MAJORITY_VOTE_EN
  // hist_q holds rx_s from one and two clocks ago; the vote lands on the mid+1 tick.
  logic [1:0] hist_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) hist_q <= 2'b11;
    else          hist_q <= {hist_q[0], rx_s};
  end

  assign bit_smp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign bit_smp = rx_s;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    scnt_d     = scnt_q + 1'b1;
    bcnt_d     = bcnt_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ready_d    = RX_read ? 1'b0 : ready_q;
    perr_out_d = perr_out_q;
    ferr_d     = ferr_q;
    ovr_d      = ovr_q;

    case (state_q)
      S_IDLE: begin
        scnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (scnt_q == START_TICK) begin
          if (!bit_smp) begin
            scnt_d  = '0;
            bcnt_d  = '0;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (scnt_q == LAST_TICK) begin
          shreg_d = {bit_smp, shreg_q[DATA_BITS-1:1]};
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == LAST_BIT) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (scnt_q == LAST_TICK) begin
          perr_d  = (^shreg_q) ^ bit_smp ^ 1'(PARITY_ODD);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (scnt_q == LAST_TICK) begin
          data_d     = shreg_q;
          perr_out_d = perr_q;
          ferr_d     = ~bit_smp;
          valid_d    = 1'b1;
          // A completing frame always wins over a same-clock read.
          if (ready_q && !RX_read) ovr_d = 1'b1;
          ready_d    = 1'b1;
          state_d    = bit_smp ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        scnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= 2'b11;
      state_q    <= S_IDLE;
      scnt_q     <= '0;
      bcnt_q     <= '0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync_q     <= {sync_q[0], RX_in};
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      bcnt_q     <= bcnt_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign RX_data_out   = data_q;
  assign RX_valid      = valid_q;
  assign RX_ready      = ready_q;
  assign parity_error  = perr_out_q;
  assign framing_error = ferr_q;
  assign overrun       = ovr_q;
  assign RXbusy        = (state_q != S_IDLE) && (state_q != S_BREAK);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: stimulus pushes expected frames, a monitor pops on RX_valid.
module tb_uart_receiver;

  localparam int OS = 16;

  logic       clock;
  logic       reset_n;
  logic       RX_in;
  logic       RX_read;
  logic [7:0] RX_data_out;
  logic       RX_valid;
  logic       RX_ready;
  logic       parity_error;
  logic       framing_error;
  logic       overrun;
  logic       RXbusy;

  uart_receiver #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_ODD(0)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .RX_in        (RX_in),
    .RX_read      (RX_read),
    .RX_data_out  (RX_data_out),
    .RX_valid     (RX_valid),
    .RX_ready     (RX_ready),
    .parity_error (parity_error),
    .framing_error(framing_error),
    .overrun      (overrun),
    .RXbusy       (RXbusy)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_vec  = 0;
  int   n_fail = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every RX_valid must match the oldest outstanding expected frame.
  always @(negedge clock) begin
    if (reset_n && RX_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_valid: got RX_valid with data %0h, expected no frame", RX_data_out);
      end else begin
        cur = exp_q.pop_front();
        check("data",          32'(RX_data_out),   32'(cur.data));
        check("parity_error",  32'(parity_error),  32'(cur.perr));
        check("framing_error", 32'(framing_error), 32'(cur.ferr));
        check("overrun",       32'(overrun),       32'(cur.ovr));
        check("ready_at_valid", 32'(RX_ready),     32'd1);
      end
    end
  end

  task automatic send_bit(input logic b, input bit glitch);
    @(negedge clock) RX_in = b;
    for (int i = 1; i < OS; i++) begin
      @(negedge clock);
      if (glitch && i == 7) RX_in = ~b;
      if (glitch && i == 8) RX_in = b;
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input logic exp_perr, input logic exp_ovr, input bit glitch);
    exp_q.push_back('{data: data, perr: exp_perr, ferr: ~stop, ovr: exp_ovr});
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(data[i], glitch);
    send_bit(par, glitch);
    send_bit(stop, glitch);
  endtask

  task automatic idle(input int n);
    @(negedge clock) RX_in = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic read_pulse();
    @(negedge clock) RX_read = 1'b1;
    @(negedge clock) RX_read = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock) reset_n = 1'b0;
    RX_in = 1'b1;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    RX_in   = 1'b1;
    RX_read = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_data",  32'(RX_data_out),   32'd0);
    check("rst_ready", 32'(RX_ready),      32'd0);
    check("rst_valid", 32'(RX_valid),      32'd0);
    check("rst_flags", 32'({parity_error, framing_error, overrun}), 32'd0);
    check("rst_busy",  32'(RXbusy),        32'd0);
    reset_n = 1'b1;
    idle(OS);

    // Clean frame, even parity.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(OS);
    read_pulse();
    check("ready_cleared", 32'(RX_ready), 32'd0);
    read_pulse();
    check("read_idle_ready", 32'(RX_ready), 32'd0);
    check("data_held", 32'(RX_data_out), 32'hA5);

    // Wrong parity bit, then an odd-weight byte with correct parity bit 1.
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(OS);
    read_pulse();
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(OS);
    read_pulse();

    // Short low glitch on the line.
    @(negedge clock) RX_in = 1'b0;
    repeat (4) @(negedge clock);
    check("glitch_busy", 32'(RXbusy), 32'd1);
    RX_in = 1'b1;
    repeat (2 * OS) @(negedge clock);
    check("glitch_idle", 32'(RXbusy), 32'd0);

    // Framing error followed by a held-low line.
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    RX_in = 1'b0;
    repeat (3 * OS) @(negedge clock);
    check("break_busy", 32'(RXbusy), 32'd0);
    idle(2 * OS);
    check("break_released", 32'(RXbusy), 32'd0);
    read_pulse();

    // Back-to-back without a read: second frame overruns.
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(OS);
    check("overrun_sticky", 32'(overrun), 32'd1);
    read_pulse();
    check("overrun_after_read", 32'(overrun), 32'd1);

    do_reset();
    check("rst2_overrun", 32'(overrun),     32'd0);
    check("rst2_data",    32'(RX_data_out), 32'd0);
    idle(OS);

    // Same pair with a read between them: no overrun.
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    read_pulse();
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(OS);
    check("no_overrun", 32'(overrun), 32'd0);

    // Abort 0x5A mid-data with reset, then a clean 0x81.
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    @(negedge clock) RX_in = 1'b1;
    repeat (8) @(negedge clock);
    check("mid_frame_busy", 32'(RXbusy), 32'd1);
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("abort_data",  32'(RX_data_out), 32'd0);
    check("abort_ready", 32'(RX_ready),    32'd0);
    check("abort_busy",  32'(RXbusy),      32'd0);
    RX_in   = 1'b1;
    reset_n = 1'b1;
    idle(2 * OS);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(OS);
    check("final_data", 32'(RX_data_out), 32'h81);

`ifdef RX_MAJORITY_VOTE_EN
    read_pulse();
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(OS);
`endif

    for (int i = 0; i < 4 * OS && exp_q.size() != 0; i++) @(negedge clock);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
